// File: rtl/filter_peak_finder_pkg.sv
// Shared widths and FSM encoding for the filter peak finder.
package filter_peak_finder_pkg;

    localparam int SIZE_FILTER_DATA = 16;
    localparam int SIZE_TIMESTAMP   = 16;
    localparam int SIZE_PEAK_WIDTH  = 8;
    localparam int SIZE_EVENT_COUNT = 16;

    typedef enum logic [1:0] {
        PK_IDLE,
        PK_ABOVE,
        PK_WAIT_BELOW,
        PK_HOLDOFF
    } peak_fsm_t;

endpackage

// File: rtl/peak_timestamp_counter.sv
// Free-running sample timestamp; advances only while analysis is enabled.
module peak_timestamp_counter
    import filter_peak_finder_pkg::*;
#(
    parameter int TIME_W = SIZE_TIMESTAMP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [TIME_W-1:0] ts
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts <= '0;
        end else if (enable) begin
            ts <= ts + TIME_W'(1);
        end
    end

endmodule

// File: rtl/filter_peak_finder.sv
// Recovers amplitude, timestamp and width of each above-threshold pulse in a filter output stream.
module filter_peak_finder
    import filter_peak_finder_pkg::*;
#(
    parameter int DATA_W    = SIZE_FILTER_DATA,
    parameter int TIME_W    = SIZE_TIMESTAMP,
    parameter int WIDTH_W   = SIZE_PEAK_WIDTH,
    parameter int MAX_WIDTH = 64,
    parameter int HOLDOFF   = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic signed [DATA_W-1:0]    input_data,
    input  logic signed [DATA_W-1:0]    threshold,
    output logic                        peak_valid,
    output logic signed [DATA_W-1:0]    peak_amplitude,
    output logic [TIME_W-1:0]           peak_time,
    output logic [WIDTH_W-1:0]          peak_width,
    output logic                        overflow_flag,
    output logic                        pileup_flag,
    output logic [SIZE_EVENT_COUNT-1:0] event_count
);

    localparam int HOLD_W = $clog2(HOLDOFF + 1);

    logic signed [DATA_W-1:0] x_r;
    logic [TIME_W-1:0]        ts, ts_r;
    logic                     above;

    peak_fsm_t                state_q, state_d;
    logic signed [DATA_W-1:0] max_q, max_d;
    logic [TIME_W-1:0]        tmax_q, tmax_d;
    logic [WIDTH_W-1:0]       width_q, width_d;
    logic [HOLD_W-1:0]        hold_q, hold_d;
    logic                     pileup_q, pileup_d;

    logic                     emit, emit_ovf;
    logic signed [DATA_W-1:0] emit_amp;
    logic [TIME_W-1:0]        emit_time;
    logic [WIDTH_W-1:0]       emit_width;

    peak_timestamp_counter #(
        .TIME_W (TIME_W)
    ) u_ts (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .ts     (ts)
    );

    // ts_r tags x_r with the counter value at the edge that captured it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_r  <= '0;
            ts_r <= '0;
        end else begin
            x_r  <= input_data;
            ts_r <= ts;
        end
    end

    assign above = x_r > threshold;

    always_comb begin
        state_d    = state_q;
        max_d      = max_q;
        tmax_d     = tmax_q;
        width_d    = width_q;
        hold_d     = hold_q;
        pileup_d   = pileup_q;
        emit       = 1'b0;
        emit_ovf   = 1'b0;
        emit_amp   = max_q;
        emit_time  = tmax_q;
        emit_width = width_q;

        if (!enable) begin
            state_d  = PK_IDLE;
            pileup_d = 1'b0;
        end else begin
            unique case (state_q)
                PK_IDLE: begin
                    if (above) begin
                        max_d   = x_r;
                        tmax_d  = ts_r;
                        width_d = WIDTH_W'(1);
                        if (MAX_WIDTH == 1) begin
                            emit       = 1'b1;
                            emit_ovf   = 1'b1;
                            emit_amp   = x_r;
                            emit_time  = ts_r;
                            emit_width = WIDTH_W'(1);
                            state_d    = PK_WAIT_BELOW;
                        end else begin
                            state_d = PK_ABOVE;
                        end
                    end
                end
                PK_ABOVE: begin
                    if (above) begin
                        width_d = width_q + WIDTH_W'(1);
                        if (x_r > max_q) begin
                            max_d  = x_r;
                            tmax_d = ts_r;
                        end
                        // Reaching the width limit ends the pulse even if this is its last sample.
                        if (width_q == WIDTH_W'(MAX_WIDTH - 1)) begin
                            emit       = 1'b1;
                            emit_ovf   = 1'b1;
                            emit_amp   = max_d;
                            emit_time  = tmax_d;
                            emit_width = width_d;
                            state_d    = PK_WAIT_BELOW;
                        end
                    end else begin
                        emit    = 1'b1;
                        hold_d  = HOLD_W'(HOLDOFF);
                        state_d = PK_HOLDOFF;
                    end
                end
                PK_WAIT_BELOW: begin
                    if (!above) begin
                        hold_d  = HOLD_W'(HOLDOFF);
                        state_d = PK_HOLDOFF;
                    end
                end
                PK_HOLDOFF: begin
                    if (above) begin
                        pileup_d = 1'b1;
                    end
                    if (hold_q == HOLD_W'(1)) begin
                        state_d = PK_IDLE;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
                default: state_d = PK_IDLE;
            endcase
            if (emit) begin
                pileup_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= PK_IDLE;
            max_q          <= '0;
            tmax_q         <= '0;
            width_q        <= '0;
            hold_q         <= '0;
            pileup_q       <= 1'b0;
            peak_valid     <= 1'b0;
            peak_amplitude <= '0;
            peak_time      <= '0;
            peak_width     <= '0;
            overflow_flag  <= 1'b0;
            pileup_flag    <= 1'b0;
            event_count    <= '0;
        end else begin
            state_q    <= state_d;
            max_q      <= max_d;
            tmax_q     <= tmax_d;
            width_q    <= width_d;
            hold_q     <= hold_d;
            pileup_q   <= pileup_d;
            peak_valid <= emit;
            if (emit) begin
                peak_amplitude <= emit_amp;
                peak_time      <= emit_time;
                peak_width     <= emit_width;
                overflow_flag  <= emit_ovf;
                pileup_flag    <= pileup_q;
                event_count    <= event_count + SIZE_EVENT_COUNT'(1);
            end
        end
    end

endmodule

// File: tb/tb_filter_peak_finder.sv
// Directed-vector bench for filter_peak_finder with hand-computed event expectations.
module tb_filter_peak_finder;

    localparam int DATA_W    = 16;
    localparam int TIME_W    = 16;
    localparam int WIDTH_W   = 8;
    localparam int MAX_WIDTH = 64;
    localparam int HOLDOFF   = 8;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     enable;
    logic signed [DATA_W-1:0] input_data;
    logic signed [DATA_W-1:0] threshold;
    logic                     peak_valid;
    logic signed [DATA_W-1:0] peak_amplitude;
    logic [TIME_W-1:0]        peak_time;
    logic [WIDTH_W-1:0]       peak_width;
    logic                     overflow_flag;
    logic                     pileup_flag;
    logic [15:0]              event_count;

    int vectors     = 0;
    int miscompares = 0;
    int strobes     = 0;

    logic [TIME_W-1:0]        tb_ts;
    logic signed [DATA_W-1:0] quiet;
    logic [TIME_W-1:0]        start;
    int                       strobes_before;

    logic signed [DATA_W-1:0] cap_amp;
    logic [TIME_W-1:0]        cap_time;
    logic [TIME_W-1:0]        cap_at;
    logic [WIDTH_W-1:0]       cap_width;
    logic                     cap_ovf;
    logic                     cap_pile;
    logic [15:0]              cap_cnt;

    always #5 clk = ~clk;

    filter_peak_finder #(
        .DATA_W    (DATA_W),
        .TIME_W    (TIME_W),
        .WIDTH_W   (WIDTH_W),
        .MAX_WIDTH (MAX_WIDTH),
        .HOLDOFF   (HOLDOFF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .input_data     (input_data),
        .threshold      (threshold),
        .peak_valid     (peak_valid),
        .peak_amplitude (peak_amplitude),
        .peak_time      (peak_time),
        .peak_width     (peak_width),
        .overflow_flag  (overflow_flag),
        .pileup_flag    (pileup_flag),
        .event_count    (event_count)
    );

    // cap_at records the bench timestamp when the strobe is seen, giving latency.
    always @(negedge clk) begin
        if (peak_valid) begin
            strobes++;
            cap_amp   = peak_amplitude;
            cap_time  = peak_time;
            cap_width = peak_width;
            cap_ovf   = overflow_flag;
            cap_pile  = pileup_flag;
            cap_cnt   = event_count;
            cap_at    = tb_ts;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    task automatic drive(input logic signed [DATA_W-1:0] v);
        input_data = v;
        @(posedge clk);
        #1;
        if (enable) tb_ts++;
    endtask

    task automatic pad(input int n);
        repeat (n) drive(quiet);
    endtask

    task automatic pad_to(input logic [TIME_W-1:0] target);
        for (int i = 0; i < 70000 && tb_ts != target; i++) drive(quiet);
    endtask

    task automatic check_event(input string tag, input int n, input logic signed [DATA_W-1:0] amp,
                               input logic [TIME_W-1:0] t, input int w, input logic ovf,
                               input logic pile, input int cnt, input logic [TIME_W-1:0] at);
        check({tag, ".strobes"}, strobes, n);
        check({tag, ".amp"}, cap_amp, amp);
        check({tag, ".time"}, cap_time, t);
        check({tag, ".width"}, cap_width, w);
        check({tag, ".ovf"}, cap_ovf, ovf);
        check({tag, ".pileup"}, cap_pile, pile);
        check({tag, ".count"}, cap_cnt, cnt);
        check({tag, ".latency"}, cap_at, at);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".valid"}, peak_valid, 0);
        check({tag, ".amp"}, peak_amplitude, 0);
        check({tag, ".time"}, peak_time, 0);
        check({tag, ".width"}, peak_width, 0);
        check({tag, ".ovf"}, overflow_flag, 0);
        check({tag, ".pileup"}, pileup_flag, 0);
        check({tag, ".count"}, event_count, 0);
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b1;
        input_data = '0;
        threshold  = 16'sd100;
        quiet      = '0;
        tb_ts      = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;

        // Basic pulse: peak 300 at ts 13, four samples above 100.
        pad_to(16'd10);
        drive(0); drive(50); drive(150); drive(300);
        drive(250); drive(120); drive(80); drive(0);
        pad(12);
        check_event("basic", 1, 300, 16'd13, 4, 1'b0, 1'b0, 1, 16'd18);

        // Tied maxima keep the earlier timestamp.
        pad_to(16'd40);
        drive(150); drive(200); drive(200); drive(90);
        pad(12);
        check_event("tie", 2, 200, 16'd41, 3, 1'b0, 1'b0, 2, 16'd45);

        // Width limit forces termination; no event until the input falls and re-crosses.
        pad_to(16'd60);
        repeat (70) drive(500);
        repeat (12) drive(100);
        check_event("ovf", 3, 500, 16'd60, 64, 1'b1, 1'b0, 3, 16'd125);
        drive(200); drive(200); drive(0);
        pad(12);
        check_event("recross", 4, 200, 16'd142, 2, 1'b0, 1'b0, 4, 16'd146);

        // Pile-up: second pulse starts 3 cycles into the first pulse's dead time.
        pad_to(16'd200);
        drive(200); drive(300); drive(0); drive(0); drive(0);
        check_event("pileA", 5, 300, 16'd201, 2, 1'b0, 1'b0, 5, 16'd204);
        repeat (15) drive(400);
        drive(0);
        pad(12);
        check_event("pileB", 6, 400, 16'd211, 9, 1'b0, 1'b1, 6, 16'd222);
        drive(150); drive(0);
        pad(12);
        check_event("pileC", 7, 150, 16'd233, 1, 1'b0, 1'b0, 7, 16'd236);

        // Asynchronous reset in the middle of a pulse.
        drive(200); drive(200); drive(200);
        strobes_before = strobes;
        #2 reset = 1'b1;
        #1;
        check_outputs_zero("async_rst");
        input_data = quiet;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tb_ts = '0;
        pad(12);
        check("async_rst.no_strobe", strobes, strobes_before);

        // Disable mid-pulse drops it and freezes the timestamp.
        drive(300); drive(300); drive(300);
        enable = 1'b0;
        drive(300); drive(300); drive(0); drive(0);
        enable = 1'b1;
        pad(12);
        check("disable.no_strobe", strobes, strobes_before);
        check("disable.count", event_count, 0);
        start = tb_ts;
        drive(150); drive(250); drive(0);
        pad(12);
        check_event("recover", strobes_before + 1, 250, start + 16'd1, 2, 1'b0, 1'b0, 1,
                    start + 16'd4);

        // Negative threshold exercises the signed compare.
        quiet = -16'sd1000;
        pad(3);
        threshold = -16'sd100;
        pad(3);
        start = tb_ts;
        drive(-16'sd150); drive(-16'sd50); drive(-16'sd20); drive(-16'sd120);
        pad(12);
        check_event("signed", strobes_before + 2, -16'sd20, start + 16'd2, 2, 1'b0, 1'b0, 2,
                    start + 16'd5);

        // Pulse spanning the timestamp wrap.
        pad_to(16'hFFFE);
        drive(-16'sd150); drive(-16'sd50); drive(-16'sd10); drive(-16'sd30); drive(-16'sd200);
        pad(12);
        check_event("wrap", strobes_before + 3, -16'sd10, 16'h0000, 3, 1'b0, 1'b0, 3, 16'h0004);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
